// File: rtl/arithmetic_fa_if.sv
// Operand/result bundle for the registered arithmetic slice.
// The master drives operands; the slave returns the registered result.
interface arithmetic_fa_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] ai;
   logic [WIDTH-1:0] bi;
   logic             ci;
   logic [1:0]       si;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             out_valid;

   modport master (
      output in_valid, ai, bi, ci, si,
      input  sum, cout, ovf, out_valid
   );

   modport slave (
      input  in_valid, ai, bi, ci, si,
      output sum, cout, ovf, out_valid
   );
endinterface

// File: rtl/arithmetic_fa.sv
// Registered ripple-carry arithmetic slice: {cout,sum} = A + Y(si,B) + ci, one-cycle latency.
// Y selects between zero, B, ~B and all-ones to cover add/sub/inc/dec/transfer.
module arithmetic_fa_slice (
   input  logic i_a,
   input  logic i_y,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_y ^ i_c;
   assign o_c = (i_a & i_y) | (i_a & i_c) | (i_y & i_c);
endmodule

module arithmetic_fa #(
   parameter int WIDTH = 1
) (
   input  logic            clk,
   input  logic            rst,
   arithmetic_fa_if.slave  bus
);
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH:0]   w_c;
   logic             w_ovf;

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_vld;

   always_comb begin
      w_y = '0;
      case (bus.si)
         2'b00:   w_y = '0;
         2'b01:   w_y = bus.bi;
         2'b10:   w_y = ~bus.bi;
         default: w_y = '1;
      endcase
   end

   assign w_c[0] = bus.ci;

   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      arithmetic_fa_slice u_slice (
         .i_a (bus.ai[k]),
         .i_y (w_y[k]),
         .i_c (w_c[k]),
         .o_s (w_s[k]),
         .o_c (w_c[k+1])
      );
   end

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

   // Data registers load every cycle; out_valid alone qualifies them.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_vld  <= 1'b0;
      end else begin
         r_sum  <= w_s;
         r_cout <= w_c[WIDTH];
         r_ovf  <= w_ovf;
         r_vld  <= bus.in_valid;
      end
   end

   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
   assign bus.out_valid = r_vld;
endmodule

// File: tb/tb_arithmetic_fa.sv
// Bench for arithmetic_fa at WIDTH=1 and WIDTH=8: directed cases plus random
// operations checked against an integer-arithmetic reference.
module tb_arithmetic_fa;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   arithmetic_fa_if #(.WIDTH(1)) if1 ();
   arithmetic_fa_if #(.WIDTH(8)) if8 ();

   arithmetic_fa #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   arithmetic_fa #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: returns {ovf, cout, sum[7:0]} from plain unsigned/signed arithmetic.
   function automatic logic [9:0] ref_op(input int w, input longint a, input longint b,
                                         input logic c, input logic [1:0] s);
      longint m, y, full, sa, sy, r;
      logic   co, ov;
      m = (longint'(1) << w) - 1;
      a = a & m;
      b = b & m;
      case (s)
         2'd0:    y = 0;
         2'd1:    y = b;
         2'd2:    y = (~b) & m;
         default: y = m;
      endcase
      full = a + y + longint'(c);
      co   = ((full >> w) & 1) != 0;
      sa   = (a >= (longint'(1) << (w-1))) ? a - (longint'(1) << w) : a;
      sy   = (y >= (longint'(1) << (w-1))) ? y - (longint'(1) << w) : y;
      r    = sa + sy + longint'(c);
      ov   = (r > (longint'(1) << (w-1)) - 1) || (r < -(longint'(1) << (w-1)));
      return {ov, co, 8'(full & m)};
   endfunction

   task automatic step8(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [1:0] s, input logic [7:0] es,
                        input logic ec, input logic eo, input logic ev);
      if8.in_valid = v; if8.ai = a; if8.bi = b; if8.ci = c; if8.si = s;
      @(posedge clk); #1;
      chk({tag, ".sum"},  64'(if8.sum),       64'(es));
      chk({tag, ".cout"}, 64'(if8.cout),      64'(ec));
      chk({tag, ".ovf"},  64'(if8.ovf),       64'(eo));
      chk({tag, ".vld"},  64'(if8.out_valid), 64'(ev));
   endtask

   task automatic step1(input string tag, input logic v, input logic a, input logic b,
                        input logic c, input logic [1:0] s, input logic es,
                        input logic ec, input logic eo, input logic ev);
      if1.in_valid = v; if1.ai = a; if1.bi = b; if1.ci = c; if1.si = s;
      @(posedge clk); #1;
      chk({tag, ".sum"},  64'(if1.sum),       64'(es));
      chk({tag, ".cout"}, 64'(if1.cout),      64'(ec));
      chk({tag, ".ovf"},  64'(if1.ovf),       64'(eo));
      chk({tag, ".vld"},  64'(if1.out_valid), 64'(ev));
   endtask

   task automatic rand8(input string tag, input logic keep_rst);
      logic [7:0] a, b;
      logic       c, v;
      logic [1:0] s;
      logic [9:0] e;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      s = 2'($urandom); v = 1'($urandom_range(0, 3) != 0);
      e = ref_op(8, longint'(a), longint'(b), c, s);
      if (keep_rst) step8(tag, v, a, b, c, s, 8'h00, 1'b0, 1'b0, 1'b0);
      else          step8(tag, v, a, b, c, s, e[7:0], e[8], e[9], v);
   endtask

   initial begin
      logic [9:0] e;
      logic a1, b1, c1, v1;
      logic [1:0] s1;

      // Reset wins over in_valid held high
      rst = 1'b1;
      if1.in_valid = 1'b1; if1.ai = 1'b1; if1.bi = 1'b1; if1.ci = 1'b1; if1.si = 2'b01;
      step8("rst8", 1'b1, 8'hFF, 8'hFF, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rst1.sum", 64'(if1.sum), 64'd0);
      chk("rst1.vld", 64'(if1.out_valid), 64'd0);
      rst = 1'b0;

      // WIDTH=1 select walk: ai=0, bi=1, ci=0
      step1("w1.s00", 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      step1("w1.s01", 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      step1("w1.s10", 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);
      step1("w1.s11", 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1);

      // WIDTH=8 directed corners
      step8("add.wrap",  1'b1, 8'hFF, 8'h01, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b1);
      step8("add.ovf",   1'b1, 8'h7F, 8'h01, 1'b0, 2'b01, 8'h80, 1'b0, 1'b1, 1'b1);
      step8("sub.borr",  1'b1, 8'h05, 8'h07, 1'b1, 2'b10, 8'hFE, 1'b0, 1'b0, 1'b1);
      step8("sub.nobr",  1'b1, 8'h07, 8'h05, 1'b1, 2'b10, 8'h02, 1'b1, 1'b0, 1'b1);
      step8("dec.zero",  1'b1, 8'h00, 8'h5A, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b1);
      step8("dec.nz",    1'b1, 8'h10, 8'h5A, 1'b0, 2'b11, 8'h0F, 1'b1, 1'b0, 1'b1);
      step8("xfer.s11",  1'b1, 8'h3C, 8'h5A, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0, 1'b1);
      step8("inc.wrap",  1'b1, 8'hFF, 8'h5A, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 1'b1);
      step8("xfer.s00",  1'b1, 8'hA5, 8'h5A, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b1);
      // Registers load even when not valid
      step8("novalid",   1'b0, 8'h80, 8'h80, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);

      // Random traffic, WIDTH=8
      for (int i = 0; i < 200; i++) rand8("rnd8", 1'b0);

      // One-cycle reset in the middle of back-to-back valid traffic
      for (int i = 0; i < 4; i++) rand8("pre.rst", 1'b0);
      rst = 1'b1;
      rand8("mid.rst", 1'b1);
      rst = 1'b0;
      step8("post.rst", 1'b1, 8'h12, 8'h34, 1'b0, 2'b01, 8'h46, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) rand8("post.rnd", 1'b0);

      // Random traffic, WIDTH=1
      for (int i = 0; i < 60; i++) begin
         a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
         s1 = 2'($urandom); v1 = 1'($urandom);
         e = ref_op(1, longint'(a1), longint'(b1), c1, s1);
         step1("rnd1", v1, a1, b1, c1, s1, e[0], e[8], e[9], v1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
